// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - modulo-N up/down counter built from J=K=T toggle cells
// Optional build macro JKCNT_SATURATE_EN: count saturates at the range ends instead of wrapping.
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             TC,
  output logic             Wrap,
  output logic             LoadErr
);

  generate
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("jk_mod_counter: WIDTH %0d outside 2..16", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("jk_mod_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
    end
  endgenerate

  // Compares run at WIDTH+1 bits so MODULUS == 2**WIDTH stays representable.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] t;
  logic             wrap_n;
  logic             load_err_n;
  logic             at_max;
  logic             at_zero;

  assign at_max  = ({1'b0, Q} == MAX_W);
  assign at_zero = (Q == '0);
  assign TC      = Up ? at_max : at_zero;

  always_comb begin
    qn         = Q;
    wrap_n     = 1'b0;
    load_err_n = 1'b0;
    if (Load) begin
      if ({1'b0, Din} < MOD_W) begin
        qn = Din;
      end else begin
        qn         = MAX_Q;
        load_err_n = 1'b1;
      end
    end else if (En) begin
      if (Up) begin
        if (at_max) begin
`ifdef JKCNT_SATURATE_EN
          qn = Q;
`else
          qn     = '0;
          wrap_n = 1'b1;
`endif
        end else begin
          qn = Q + ONE_Q;
        end
      end else begin
        if (at_zero) begin
`ifdef JKCNT_SATURATE_EN
          qn = Q;
`else
          qn     = MAX_Q;
          wrap_n = 1'b1;
`endif
        end else begin
          qn = Q - ONE_Q;
        end
      end
    end
  end

  // Each cell gets J=K=t[i], so only the hold and toggle rows are ever exercised.
  assign t = Q ^ qn;

  always_ff @(posedge Clock) begin
    if (Clear) begin
      Q       <= '0;
      Qbar    <= '1;
      Wrap    <= 1'b0;
      LoadErr <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({t[i], t[i]})
          2'b00:   begin Q[i] <= Q[i];  Qbar[i] <= ~Q[i]; end
          2'b01:   begin Q[i] <= 1'b0;  Qbar[i] <= 1'b1;  end
          2'b10:   begin Q[i] <= 1'b1;  Qbar[i] <= 1'b0;  end
          default: begin Q[i] <= ~Q[i]; Qbar[i] <= Q[i];  end
        endcase
      end
      Wrap    <= wrap_n;
      LoadErr <= load_err_n;
    end
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - directed plus randomized check of jk_mod_counter against an arithmetic model
module tb_jk_mod_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;
  localparam int MASK    = (1 << WIDTH) - 1;

  logic             Clock = 1'b0;
  logic             Clear = 1'b1;
  logic             En    = 1'b0;
  logic             Up    = 1'b0;
  logic             Load  = 1'b0;
  logic [WIDTH-1:0] Din   = '0;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;
  logic             TC;
  logic             Wrap;
  logic             LoadErr;

  int checks   = 0;
  int failures = 0;

  int m_q    = 0;
  int m_wrap = 0;
  int m_err  = 0;

  always #5 Clock = ~Clock;

  jk_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .Clock   (Clock),
    .Clear   (Clear),
    .En      (En),
    .Up      (Up),
    .Load    (Load),
    .Din     (Din),
    .Q       (Q),
    .Qbar    (Qbar),
    .TC      (TC),
    .Wrap    (Wrap),
    .LoadErr (LoadErr)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int exp_tc(input int up);
    return up ? int'(m_q == MODULUS - 1) : int'(m_q == 0);
  endfunction

  // Reference: apply the edge rules with plain modular arithmetic.
  task automatic model_edge(input int c, input int l, input int e, input int u, input int d);
    m_wrap = 0;
    m_err  = 0;
    if (c) begin
      m_q = 0;
    end else if (l) begin
      if (d < MODULUS) m_q = d;
      else begin m_q = MODULUS - 1; m_err = 1; end
    end else if (e) begin
      if (u) begin
`ifdef JKCNT_SATURATE_EN
        if (m_q < MODULUS - 1) m_q = m_q + 1;
`else
        m_wrap = int'(m_q == MODULUS - 1);
        m_q    = (m_q + 1) % MODULUS;
`endif
      end else begin
`ifdef JKCNT_SATURATE_EN
        if (m_q > 0) m_q = m_q - 1;
`else
        m_wrap = int'(m_q == 0);
        m_q    = (m_q + MODULUS - 1) % MODULUS;
`endif
      end
    end
  endtask

  task automatic apply(input int c, input int l, input int e, input int u, input int d);
    @(negedge Clock);
    Clear = c[0];
    Load  = l[0];
    En    = e[0];
    Up    = u[0];
    Din   = d[WIDTH-1:0];
    #1;
    check("tc_pre", 32'(TC), 32'(exp_tc(u)));
    @(posedge Clock);
    model_edge(c, l, e, u, d);
    #1;
    check("q", 32'(Q), 32'(m_q));
    check("qbar", 32'(Qbar), 32'(~m_q & MASK));
    check("wrap", 32'(Wrap), 32'(m_wrap));
    check("load_err", 32'(LoadErr), 32'(m_err));
    check("tc_post", 32'(TC), 32'(exp_tc(u)));
    check("pulse_excl", 32'(Wrap & LoadErr), 32'(0));
  endtask

  initial begin
    // Reset with every other control asserted.
    apply(1, 1, 1, 1, 5);
    apply(1, 1, 1, 1, 5);
    check("reset_q", 32'(Q), 32'(0));
    check("reset_qbar", 32'(Qbar), 32'(MASK));

    for (int i = 0; i < 12; i++) apply(0, 0, 1, 1, 0);

    apply(0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) apply(0, 0, 1, 0, 0);

    // Clamp with En also high, then a legal load.
    apply(0, 1, 1, 1, 12);
    apply(0, 1, 0, 1, 3);
    apply(0, 0, 0, 1, 0);

    apply(0, 1, 0, 1, 6);
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 1, 0);
    apply(1, 0, 1, 1, 0);

    apply(0, 1, 0, 1, 8);
    for (int i = 0; i < 3; i++) apply(0, 0, 1, 1, 0);
    apply(0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) apply(0, 0, 1, 0, 0);

    // Boundary loads across the whole Din range.
    for (int d = 0; d <= MASK; d++) apply(0, 1, 0, d & 1, d);

    for (int i = 0; i < 600; i++) begin
      apply(int'($urandom_range(0, 31) == 0),
            int'($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 5) != 0 ? (i / 40) % 2 : $urandom_range(0, 1)),
            int'($urandom_range(0, MASK)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
